// File: rtl/nor_rr_sched.sv
// nor_rr_sched
// Round-robin scheduler that shares one registered bitwise-NOR datapath
// between NUM_REQ requesters. One requester is granted at a time. Its two
// operands are captured, the NOR is computed on the following edge, and the
// result is held behind a valid/ready handshake, tagged with the owner id.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   req_vec       per-requester request, bit k = requester k
//   in_data1_bus  operand 1, requester k on bits [k*WIDTH +: WIDTH]
//   in_data2_bus  operand 2, same packing
//   out_ready     consumer accepts the presented result
//   gnt_vec       one-hot, one-cycle pulse: requester k's operands captured
//   out_data      NOR result, kept after out_valid drops
//   out_id        index of the requester that owns out_data
//   out_valid     result valid
//   busy          high whenever the scheduler is not idle
module nor_rr_sched #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_vec,
  input  logic [NUM_REQ*WIDTH-1:0] in_data1_bus,
  input  logic [NUM_REQ*WIDTH-1:0] in_data2_bus,
  input  logic                     out_ready,
  output logic [NUM_REQ-1:0]       gnt_vec,
  output logic [WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_valid,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Registered state and outputs
  state_t              r_state;
  logic [ID_W-1:0]     r_last_id;
  logic [WIDTH-1:0]    r_op1;
  logic [WIDTH-1:0]    r_op2;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [WIDTH-1:0]    r_data;
  logic [ID_W-1:0]     r_id;
  logic                r_valid;
  logic                r_busy;

  // Next-state values
  state_t              w_state_next;
  logic [ID_W-1:0]     w_last_id_next;
  logic [WIDTH-1:0]    w_op1_next;
  logic [WIDTH-1:0]    w_op2_next;
  logic [NUM_REQ-1:0]  w_gnt_next;
  logic [WIDTH-1:0]    w_data_next;
  logic [ID_W-1:0]     w_id_next;
  logic                w_valid_next;
  logic                w_busy_next;

  // Arbitration
  logic                w_found;
  logic [ID_W-1:0]     w_win;
  int                  w_cand;

  // Per-requester operand views of the packed buses
  logic [WIDTH-1:0]    w_op1_arr [NUM_REQ];
  logic [WIDTH-1:0]    w_op2_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_op1_arr[gi] = in_data1_bus[gi*WIDTH +: WIDTH];
    assign w_op2_arr[gi] = in_data2_bus[gi*WIDTH +: WIDTH];
  end

  // Search starts just after the last winner, so the previous owner is
  // considered last and continuous requesters rotate strictly.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = (int'(r_last_id) + off) % NUM_REQ;
      if (!w_found && req_vec[ID_W'(w_cand)]) begin
        w_found = 1'b1;
        w_win   = ID_W'(w_cand);
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_last_id_next = r_last_id;
    w_op1_next     = r_op1;
    w_op2_next     = r_op2;
    w_gnt_next     = '0;
    w_data_next    = r_data;
    w_id_next      = r_id;
    w_valid_next   = r_valid;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_op1_next     = w_op1_arr[w_win];
          w_op2_next     = w_op2_arr[w_win];
          w_gnt_next     = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
          w_last_id_next = w_win;
          w_state_next   = CALC;
        end
      end
      CALC: begin
        w_data_next  = ~(r_op1 | r_op2);
        w_id_next    = r_last_id;
        w_valid_next = 1'b1;
        w_state_next = OUT;
      end
      OUT: begin
        if (out_ready) begin
          w_valid_next = 1'b0;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_valid_next = 1'b0;
        w_state_next = IDLE;
      end
    endcase

    // Registered alongside the state so it always equals (state != IDLE)
    w_busy_next = (w_state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last_id <= ID_W'(NUM_REQ - 1);
      r_op1     <= '0;
      r_op2     <= '0;
      r_gnt     <= '0;
      r_data    <= '0;
      r_id      <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_last_id <= w_last_id_next;
      r_op1     <= w_op1_next;
      r_op2     <= w_op2_next;
      r_gnt     <= w_gnt_next;
      r_data    <= w_data_next;
      r_id      <= w_id_next;
      r_valid   <= w_valid_next;
      r_busy    <= w_busy_next;
    end
  end

  assign gnt_vec   = r_gnt;
  assign out_data  = r_data;
  assign out_id    = r_id;
  assign out_valid = r_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_nor_rr_sched.sv
// tb_nor_rr_sched
// Self-checking bench for nor_rr_sched (WIDTH=4, NUM_REQ=4, ID_W=2).
// A transaction-level reference model predicts every output each cycle;
// table vectors and hand sequences add constant expectations on top.
module tb_nor_rr_sched;

  localparam int WIDTH   = 4;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_vec;
  logic [NUM_REQ*WIDTH-1:0] in_data1_bus;
  logic [NUM_REQ*WIDTH-1:0] in_data2_bus;
  logic                     out_ready;
  logic [NUM_REQ-1:0]       gnt_vec;
  logic [WIDTH-1:0]         out_data;
  logic [ID_W-1:0]          out_id;
  logic                     out_valid;
  logic                     busy;

  nor_rr_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_vec      (req_vec),
    .in_data1_bus (in_data1_bus),
    .in_data2_bus (in_data2_bus),
    .out_ready    (out_ready),
    .gnt_vec      (gnt_vec),
    .out_data     (out_data),
    .out_id       (out_id),
    .out_valid    (out_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int m_last;     // id granted most recently
  int m_phase;    // 0 waiting for request, 1 operands held, 2 result presented
  int m_gnt, m_valid, m_data, m_id, m_res, m_owner;

  function automatic void m_reset();
    m_last = NUM_REQ - 1; m_phase = 0;
    m_gnt = 0; m_valid = 0; m_data = 0; m_id = 0; m_res = 0; m_owner = 0;
  endfunction

  function automatic void m_update(input int req, input logic [15:0] d1,
                                   input logic [15:0] d2, input int rdy);
    int a, b;
    bit found;
    m_gnt = 0;
    if (m_phase == 0) begin
      found = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
        int k;
        k = (m_last + off) % NUM_REQ;
        if (!found && ((req >> k) & 1) == 1) begin
          found   = 1;
          a       = int'(d1 >> (WIDTH * k)) & 15;
          b       = int'(d2 >> (WIDTH * k)) & 15;
          m_res   = (~(a | b)) & 15;
          m_owner = k;
          m_gnt   = 1 << k;
          m_last  = k;
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      m_data = m_res; m_id = m_owner; m_valid = 1; m_phase = 2;
    end else if (rdy != 0) begin
      m_valid = 0; m_phase = 0;
    end
  endfunction

  // One clock: capture the inputs seen at the edge, advance the model,
  // compare every output 1 time unit after the edge.
  task automatic step();
    logic [3:0]  r;
    logic [15:0] a, b;
    logic        rd;
    r = req_vec; a = in_data1_bus; b = in_data2_bus; rd = out_ready;
    @(posedge clk); #1;
    if (out_valid && rd) $display("txn accepted id=%0d data=%h", out_id, out_data);
    m_update(int'(r), a, b, int'(rd));
    chk("model_gnt",   32'(gnt_vec),   32'(m_gnt));
    chk("model_valid", 32'(out_valid), 32'(m_valid));
    chk("model_data",  32'(out_data),  32'(m_data));
    chk("model_id",    32'(out_id),    32'(m_id));
    chk("model_busy",  32'(busy),      32'(m_phase != 0));
  endtask

  // Reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #2; rst = 1'b1; #1;
    chk("rst_gnt",   32'(gnt_vec),   32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data",  32'(out_data),  32'h0);
    chk("rst_id",    32'(out_id),    32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        rdy;
    logic [3:0]  gnt;
    logic        valid;
    logic [3:0]  data;
    logic [1:0]  id;
    logic        busy;
  } vec_t;

  vec_t tbl [20];
  logic [3:0] rr_nor [4];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- vector table ----------------
    // Round robin with req 1111: a_k = {4,3,2,1}, b_k = {8,4,2,1}
    rr_nor[0] = 4'hE; rr_nor[1] = 4'hD; rr_nor[2] = 4'h8; rr_nor[3] = 4'h3;
    for (int i = 0; i < 15; i++) begin
      int g, k, ph;
      g = i / 3; k = g % 4; ph = i % 3;
      tbl[i].req = 4'b1111; tbl[i].d1 = 16'h4321; tbl[i].d2 = 16'h8421; tbl[i].rdy = 1'b1;
      if (ph == 0) begin
        tbl[i].gnt   = 4'(1 << k);
        tbl[i].valid = 1'b0;
        tbl[i].data  = (g == 0) ? 4'h0 : rr_nor[(g - 1) % 4];
        tbl[i].id    = (g == 0) ? 2'd0 : 2'((g - 1) % 4);
        tbl[i].busy  = 1'b1;
      end else begin
        tbl[i].gnt   = 4'b0000;
        tbl[i].valid = (ph == 1);
        tbl[i].data  = rr_nor[k];
        tbl[i].id    = 2'(k);
        tbl[i].busy  = (ph == 1);
      end
    end
    // Requests withdrawn: stays idle
    tbl[15] = '{4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'hE, 2'd0, 1'b0};
    // Single request: a=0011, b=0101 -> 1000, valid for one cycle
    tbl[16] = '{4'b0001, 16'h0003, 16'h0005, 1'b1, 4'b0001, 1'b0, 4'hE, 2'd0, 1'b1};
    tbl[17] = '{4'b0000, 16'h0003, 16'h0005, 1'b1, 4'b0000, 1'b1, 4'h8, 2'd0, 1'b1};
    tbl[18] = '{4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h8, 2'd0, 1'b0};
    tbl[19] = '{4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h8, 2'd0, 1'b0};

    rst = 1'b0; req_vec = '0; in_data1_bus = '0; in_data2_bus = '0; out_ready = 1'b1;
    m_reset();
    do_reset();

    for (int i = 0; i < 20; i++) begin
      req_vec = tbl[i].req; in_data1_bus = tbl[i].d1; in_data2_bus = tbl[i].d2;
      out_ready = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_gnt", i),   32'(gnt_vec),   32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_data", i),  32'(out_data),  32'(tbl[i].data));
      chk($sformatf("tbl%0d_id", i),    32'(out_id),    32'(tbl[i].id));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),      32'(tbl[i].busy));
    end

    // ---------------- back-pressure ----------------
    req_vec = 4'b0100; in_data1_bus = 16'h0500; in_data2_bus = 16'h0200; out_ready = 1'b0;
    step();
    chk("bp_grant", 32'(gnt_vec), 32'h4);
    req_vec = 4'b1111;
    step();
    chk("bp_valid_rise", 32'(out_valid), 32'h1);
    chk("bp_data_rise",  32'(out_data),  32'h8);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
      chk("bp_hold_data",  32'(out_data),  32'h8);
      chk("bp_hold_id",    32'(out_id),    32'h2);
      chk("bp_hold_gnt",   32'(gnt_vec),   32'h0);
      chk("bp_hold_busy",  32'(busy),      32'h1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(out_valid), 32'h0);
    step();
    chk("bp_next_grant", 32'(gnt_vec), 32'h8);
    step();
    chk("rst_pre_valid", 32'(out_valid), 32'h1);

    // ---------------- reset during OUT with all requests pending ----------------
    do_reset();
    step();
    chk("post_rst_grant", 32'(gnt_vec), 32'h1);
    req_vec = 4'b0000;
    repeat (4) step();

    // ---------------- exhaustive datapath through requester 2 ----------------
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [15:0] d1, d2;
        d1 = 16'($urandom); d2 = 16'($urandom);
        d1[11:8] = 4'(a); d2[11:8] = 4'(b);
        req_vec = 4'b0100; in_data1_bus = d1; in_data2_bus = d2; out_ready = 1'b1;
        step();
        req_vec = 4'b0000;
        step();
        chk("exh_data", 32'(out_data), 32'((~(a | b)) & 15));
        chk("exh_id",   32'(out_id),   32'h2);
        step();
      end
    end

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 1500; i++) begin
      req_vec      = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      in_data1_bus = 16'($urandom);
      in_data2_bus = 16'($urandom);
      out_ready    = ($urandom_range(0, 3) != 0);
      step();
    end
    req_vec = 4'b0000; out_ready = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nor_rr_sched.md
Name: nor_rr_sched

Overview:
- Round-robin scheduler that shares one registered WIDTH-bit NOR datapath between NUM_REQ requesters.
- Grants one requester at a time and captures its two operands.
- Computes out_data = ~(in_data1 | in_data2) and presents the result with a valid/ready handshake, tagged with the requester id.
- Sits between requester logic and downstream consumers wherever the NOR unit is a shared resource.

Parameters:
- WIDTH, 4, operand/result width in bits.
- NUM_REQ, 4, number of requesters (>=2).
- ID_W, 2, width of out_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_vec  input  NUM_REQ  per-requester request; bit k = requester k.
- in_data1_bus  input  NUM_REQ*WIDTH  operand 1; requester k on bits [k*WIDTH +: WIDTH].
- in_data2_bus  input  NUM_REQ*WIDTH  operand 2; same packing.
- out_ready  input  1  consumer accepts the result.
- gnt_vec  output  NUM_REQ  one-hot, one-cycle pulse: operands of requester k were captured.
- out_data  output  WIDTH  NOR result.
- out_id  output  ID_W  index of the requester that owns out_data.
- out_valid  output  1  result valid.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate, discards any in-flight operation):
  - state = IDLE; gnt_vec = 0; out_valid = 0; out_data = 0; out_id = 0; busy = 0.
  - Internal operand registers = 0; last_id = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, CALC, OUT. All outputs are registered.
- IDLE:
  - req_vec is sampled only in this state.
  - If req_vec != 0, pick winner k: the first set bit searching last_id+1, last_id+2, ..., wrapping modulo NUM_REQ.
  - At the clock edge: latch in_data1/in_data2 slices of k, set gnt_vec[k] = 1 for exactly one cycle, set last_id = k, go to CALC.
  - If req_vec == 0: stay in IDLE, gnt_vec = 0.
- CALC:
  - gnt_vec returns to 0.
  - At the edge: out_data = ~(op1 | op2) (bitwise, WIDTH bits, no extension), out_id = last_id, out_valid = 1, go to OUT.
- OUT:
  - out_valid, out_data and out_id are held stable.
  - On an edge with out_ready = 1: out_valid = 0, go to IDLE. Otherwise stay in OUT (back-pressure).
  - out_data keeps its last value after out_valid drops.
- Latency and throughput:
  - Request sampled at edge E0 -> gnt_vec high after E0 -> out_valid high after E1.
  - With out_ready held at 1, out_valid drops after E2, and the next grant can occur at E3.
  - Maximum rate: one operation per 3 cycles.
- Requester contract:
  - Hold req and operands stable until gnt seen.
  - Drop req within 1 cycle of gnt unless another operation is wanted.
  - A req still high when the FSM returns to IDLE is treated as a new request.
- Fairness:
  - The requester granted last has lowest priority in the next arbitration.
  - Continuous requesters are served in strict rotation.
  - A lone requester may be granted repeatedly.
- Requests arriving in CALC or OUT are not lost if held; they are arbitrated on return to IDLE.
- out_ready while out_valid = 0 is ignored.
- Reset asserted in any state aborts the operation; no partial result is emitted.

Test Plan:
- Reset check: assert rst mid-cycle -> immediately gnt_vec = 0, out_valid = 0, out_data = 0, out_id = 0, busy = 0.
- Single request, WIDTH=4: req_vec = 4'b0001, a = 4'b0011, b = 4'b0101, out_ready = 1.
  - gnt_vec = 4'b0001 one cycle after the sampling edge.
  - Next cycle: out_valid = 1, out_data = 4'b1000, out_id = 0.
  - out_valid lasts 1 cycle.
- Round-robin: req_vec = 4'b1111 held, out_ready = 1.
  - Grants in order 0, 1, 2, 3, 0, spaced 3 cycles apart.
  - Each out_data = ~(a_k | b_k) for distinct per-requester operands; out_id matches.
- Back-pressure: out_ready = 0 for 5 cycles during OUT.
  - out_valid, out_data and out_id stay constant; no gnt pulse; busy = 1.
  - On out_ready = 1, out_valid drops next edge; the next grant follows one edge later.
- Reset during OUT with req_vec = 4'b1111 pending:
  - out_valid drops asynchronously.
  - First grant after reset release goes to requester 0 (last_id restored).
- Exhaustive datapath via requester 2: all 256 (a, b) pairs.
  - out_data == ~(a | b) and out_id == 2 every time; error counter ends at 0.
